// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the unified-memory pins served by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              grant0, grant1;
    logic              done0, done1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memwrite, mem_memread;
    logic [DATA_W-1:0] mem_out32;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out32,
        output grant0, grant1, done0, done1, rdata0, rdata1, busy,
               mem_address, mem_writeData, mem_memwrite, mem_memread
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out32,
        input  grant0, grant1, done0, done1, rdata0, rdata1, busy,
               mem_address, mem_writeData, mem_memwrite, mem_memread
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer sharing one word memory between the
// instruction-fetch port (0) and the data load/store port (1).
module mem_port_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              last;      // port granted most recently
    logic              cur;       // port owning the access in flight
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              strobe_wr, strobe_rd;
    logic              grant0_q, grant1_q, done0_q, done1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              any_req, win;

    assign any_req = bus.req0 | bus.req1;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        win        = bus.req1;
        state_next = state;
        if (bus.req0 && bus.req1) win = ~last;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (cnt == '0) state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            cur       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            strobe_wr <= 1'b0;
            strobe_rd <= 1'b0;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state    <= state_next;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    cur       <= win;
                    last      <= win;
                    lat_we    <= win ? bus.we1 : bus.we0;
                    lat_addr  <= win ? bus.addr1 : bus.addr0;
                    lat_wdata <= win ? bus.wdata1 : bus.wdata0;
                    strobe_wr <= win ? bus.we1 : bus.we0;
                    strobe_rd <= win ? ~bus.we1 : ~bus.we0;
                    grant0_q  <= ~win;
                    grant1_q  <= win;
                    cnt       <= CNT_W'(MEM_LAT - 1);
                end
                ACCESS: begin
                    // Strobes fall on the same edge that moves us into CAPTURE.
                    if (cnt == '0) begin
                        strobe_wr <= 1'b0;
                        strobe_rd <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!lat_we) begin
                        if (cur) rdata1_q <= bus.mem_out32;
                        else     rdata0_q <= bus.mem_out32;
                    end
                    done0_q <= ~cur;
                    done1_q <= cur;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant0        = grant0_q;
    assign bus.grant1        = grant1_q;
    assign bus.done0         = done0_q;
    assign bus.done1         = done1_q;
    assign bus.rdata0        = rdata0_q;
    assign bus.rdata1        = rdata1_q;
    assign bus.busy          = (state != IDLE);
    assign bus.mem_address   = lat_addr;
    assign bus.mem_writeData = lat_wdata;
    assign bus.mem_memwrite  = strobe_wr;
    assign bus.mem_memread   = strobe_rd;
endmodule
